// File: rtl/flipflop_pkg.sv
// Shared mode encodings for the flip-flop bank and its per-bit cell.
package flipflop_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

endpackage : flipflop_pkg

// File: rtl/ff_cell.sv
// Single-bit next-state function for one flip-flop of the bank.
// Purely combinational; the state register lives in the parent.
module ff_cell
    import flipflop_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       q,
    output logic       q_nxt,
    output logic       illegal
);

    // Next state per mode; SR with S=R=1 holds the bit and flags it.
    always_comb begin
        q_nxt   = q;
        illegal = 1'b0;
        unique case (mode)
            MODE_JK: begin
                unique case ({j, k})
                    2'b00: q_nxt = q;
                    2'b01: q_nxt = 1'b0;
                    2'b10: q_nxt = 1'b1;
                    2'b11: q_nxt = ~q;
                endcase
            end
            MODE_SR: begin
                unique case ({j, k})
                    2'b00: q_nxt = q;
                    2'b01: q_nxt = 1'b0;
                    2'b10: q_nxt = 1'b1;
                    2'b11: begin
                        q_nxt   = q;
                        illegal = 1'b1;
                    end
                endcase
            end
            MODE_D:  q_nxt = j;
            MODE_T:  q_nxt = q ^ j;
        endcase
    end

endmodule : ff_cell

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH flip-flops sharing one runtime mode (JK/SR/D/T), with
// parallel load, clock enable, sticky SR-illegal flag, registered change
// mask and a saturating change-event counter.
module jk_ff_bank
    import flipflop_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sr_err,
    output logic [WIDTH-1:0] chg,
    output logic [CNT_W-1:0] chg_cnt
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_chg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic [WIDTH-1:0] w_cell_nxt;
    logic [WIDTH-1:0] w_cell_ill;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_diff;
    logic             w_err_set;
    logic             w_cnt_sat;

    // One next-state cell per bit; mode is shared across the bank.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        ff_cell u_cell (
            .mode    (mode),
            .j       (j[g]),
            .k       (k[g]),
            .q       (r_q[g]),
            .q_nxt   (w_cell_nxt[g]),
            .illegal (w_cell_ill[g])
        );
    end

    // Load beats enable; enable gates the mode-based update.
    always_comb begin
        w_q_nxt = r_q;
        if (load)
            w_q_nxt = load_val;
        else if (en)
            w_q_nxt = w_cell_nxt;
    end

    assign w_diff    = w_q_nxt ^ r_q;
    // Illegal SR input only counts when the mode update actually applies.
    assign w_err_set = en && !load && (|w_cell_ill);
    assign w_cnt_sat = &r_cnt;

    // State register and registered change mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= RST_VAL;
            r_chg <= '0;
        end else begin
            r_q   <= w_q_nxt;
            r_chg <= w_diff;
        end
    end

    // Change-event counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if ((|w_diff) && !w_cnt_sat)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    // Sticky SR error; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_err_set)
            r_err <= 1'b1;
        else if (clr_err)
            r_err <= 1'b0;
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign chg     = r_chg;
    assign chg_cnt = r_cnt;
    assign sr_err  = r_err;

endmodule : jk_ff_bank
